// File: rtl/uart_rx_param_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_param_pkg
// Shared UART receive-side types and constants.
//   parity_e         : parity configuration of a receiver instance
//   uart_rx_state_e  : receiver frame FSM states
//   DEFAULT_*        : default bit timing and data width
//   majority3        : 2-of-3 vote used by the input sampler
// ---------------------------------------------------------------------------
package uart_rx_param_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_rx_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 87;
  localparam int DEFAULT_DATA_WIDTH   = 8;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_param_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
// Brings the asynchronous serial line into the clock domain and conditions it.
//   clk, rst      : system clock, asynchronous active-high reset
//   i_rx_serial   : raw serial line (idle high)
//   o_rx_sync     : line after the 2-flop synchroniser
//   o_rx_voted    : majority of the last three synchronised samples
//   o_start_edge  : one-cycle pulse on a synchronised 1 -> 0 transition
// ---------------------------------------------------------------------------
module uart_rx_sampler
  import uart_rx_param_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_rx_serial,
  output logic o_rx_sync,
  output logic o_rx_voted,
  output logic o_start_edge
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [1:0] hist_q, hist_d;
  logic [1:0] prime_q, prime_d;
  logic       armed_q, armed_d;

  // Edge detection is only armed once a real (post-reset) high level has
  // reached the synchroniser output. prime_q marks when the reset-preset 1s
  // have been flushed, so a line held low through reset never looks like a
  // falling edge.
  always_comb begin
    sync1_d = i_rx_serial;
    sync2_d = sync1_q;
    hist_d  = {hist_q[0], sync2_q};
    prime_d = {prime_q[0], 1'b1};
    armed_d = armed_q | (prime_q[1] & sync2_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 2'b11;
      prime_q <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
      prime_q <= prime_d;
      armed_q <= armed_d;
    end
  end

  // The vote window includes the newest synchronised sample, so voting adds
  // no latency beyond the synchroniser itself.
  assign o_rx_sync    = sync2_q;
  assign o_rx_voted   = majority3(sync2_q, hist_q[0], hist_q[1]);
  assign o_start_edge = armed_q & hist_q[0] & ~sync2_q;

endmodule

// File: rtl/uart_rx_param.sv
// ---------------------------------------------------------------------------
// uart_rx_param
// Parametrised UART receiver: DATA_WIDTH data bits LSB first, optional
// even/odd parity, 1 or 2 stop bits, with parity/framing/break reporting.
//   clk, rst       : system clock, asynchronous active-high reset
//   i_rx_serial    : raw serial line, idle high
//   o_rx_data      : received word, updated with each o_rx_valid
//   o_rx_valid     : one-cycle pulse, data and flags valid
//   o_parity_err   : parity mismatch on the delivered frame
//   o_frame_err    : a stop bit was sampled low on the delivered frame
//   o_break        : all-zero frame including the first stop bit
// ---------------------------------------------------------------------------
module uart_rx_param
  import uart_rx_param_pkg::*;
#(
  parameter int      DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int      CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter parity_e PARITY_MODE  = PARITY_NONE,
  parameter int      STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_rx_serial,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_break
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic             LAST_STOP = (STOP_BITS == 2);
  localparam logic             HAS_PARITY = (PARITY_MODE != PARITY_NONE);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
    $error("uart_rx_param: DATA_WIDTH must be 5..9");
  end
  if (CLKS_PER_BIT < 8) begin : g_bad_clks_per_bit
    $error("uart_rx_param: CLKS_PER_BIT must be >= 8");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end

  logic rx_sync;
  logic rx_voted;
  logic start_edge;

  uart_rx_sampler u_sampler (
    .clk          (clk),
    .rst          (rst),
    .i_rx_serial  (i_rx_serial),
    .o_rx_sync    (rx_sync),
    .o_rx_voted   (rx_voted),
    .o_start_edge (start_edge)
  );

  uart_rx_state_e        state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic                  stop_idx_q, stop_idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_bit_q, par_bit_d;
  logic                  par_flag_q, par_flag_d;
  logic                  frame_flag_q, frame_flag_d;
  logic                  first_stop_low_q, first_stop_low_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  parity_err_q, parity_err_d;
  logic                  frame_err_q, frame_err_d;
  logic                  break_q, break_d;

  logic                  frame_now;
  logic                  first_low_now;
  logic                  break_par_ok;

  // A break needs a low parity bit too, when one is present.
  assign break_par_ok = !HAS_PARITY || !par_bit_q;

  // Frame FSM. Data bits are shifted in from the MSB end so that after
  // DATA_WIDTH samples the first (LSB) wire bit sits at position 0.
  // Output flags default to 0 so they can only be seen alongside valid.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    bit_idx_d        = bit_idx_q;
    stop_idx_d       = stop_idx_q;
    shift_d          = shift_q;
    par_bit_d        = par_bit_q;
    par_flag_d       = par_flag_q;
    frame_flag_d     = frame_flag_q;
    first_stop_low_d = first_stop_low_q;
    rx_data_d        = rx_data_q;
    rx_valid_d       = 1'b0;
    parity_err_d     = 1'b0;
    frame_err_d      = 1'b0;
    break_d          = 1'b0;
    frame_now        = frame_flag_q | ~rx_voted;
    first_low_now    = (stop_idx_q == 1'b0) ? ~rx_voted : first_stop_low_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d            = '0;
        bit_idx_d        = '0;
        stop_idx_d       = 1'b0;
        par_bit_d        = 1'b0;
        par_flag_d       = 1'b0;
        frame_flag_d     = 1'b0;
        first_stop_low_d = 1'b0;
        if (start_edge) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          state_d = rx_voted ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d     = '0;
          shift_d   = {rx_voted, shift_q[DATA_WIDTH-1:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == LAST_IDX) begin
            state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_PARITY: begin
        if (cnt_q == BIT_END) begin
          cnt_d      = '0;
          par_bit_d  = rx_voted;
          par_flag_d = (PARITY_MODE == PARITY_ODD) ? ~(^shift_q ^ rx_voted)
                                                   :  (^shift_q ^ rx_voted);
          state_d    = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d            = '0;
          frame_flag_d     = frame_now;
          first_stop_low_d = first_low_now;
          if (stop_idx_q == LAST_STOP) begin
            rx_valid_d   = 1'b1;
            rx_data_d    = shift_q;
            parity_err_d = par_flag_q;
            frame_err_d  = frame_now;
            break_d      = (shift_q == '0) & break_par_ok & first_low_now;
            // A clean frame returns straight to IDLE so a start bit can
            // follow the stop bit with no idle gap.
            state_d      = frame_now ? ST_WAIT_HIGH : ST_IDLE;
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_WAIT_HIGH: begin
        if (rx_sync) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      bit_idx_q        <= '0;
      stop_idx_q       <= 1'b0;
      shift_q          <= '0;
      par_bit_q        <= 1'b0;
      par_flag_q       <= 1'b0;
      frame_flag_q     <= 1'b0;
      first_stop_low_q <= 1'b0;
      rx_data_q        <= '0;
      rx_valid_q       <= 1'b0;
      parity_err_q     <= 1'b0;
      frame_err_q      <= 1'b0;
      break_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      bit_idx_q        <= bit_idx_d;
      stop_idx_q       <= stop_idx_d;
      shift_q          <= shift_d;
      par_bit_q        <= par_bit_d;
      par_flag_q       <= par_flag_d;
      frame_flag_q     <= frame_flag_d;
      first_stop_low_q <= first_stop_low_d;
      rx_data_q        <= rx_data_d;
      rx_valid_q       <= rx_valid_d;
      parity_err_q     <= parity_err_d;
      frame_err_q      <= frame_err_d;
      break_q          <= break_d;
    end
  end

  assign o_rx_data    = rx_data_q;
  assign o_rx_valid   = rx_valid_q;
  assign o_parity_err = parity_err_q;
  assign o_frame_err  = frame_err_q;
  assign o_break      = break_q;

endmodule
